// File: rtl/uart_port.sv
// 8N1 UART with a CPU read/write handshake and an optional receive FIFO.
// Define UART_PORT_RX_FIFO_EN for an RX_DEPTH-entry FIFO; otherwise RX storage is one holding register.
//
// state | meaning
// IDLE  | line idle, waiting for a byte (TX) or a start edge (RX)
// START | start bit (RX: validated at its midpoint)
// DATA  | 8 data bits, LSB first
// STOP  | stop bit
module uart_port #(
   parameter int CLKS_PER_BIT = 434,
   parameter int RX_DEPTH     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       uartReadReq,
   output logic       uartReadAck,
   output logic [7:0] uartReadData,
   input  logic       uartWriteReq,
   input  logic [7:0] uartWriteData,
   output logic       uartWriteReady,
   input  logic       rxd,
   output logic       txd,
   output logic       rxErr,
   output logic       rxOverrun
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
`ifdef UART_PORT_RX_FIFO_EN
   localparam int DEPTH = RX_DEPTH;
   localparam int PTR_W = $clog2(RX_DEPTH);
`else
   localparam int DEPTH = 1;
`endif
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
   localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   uart_state_t      tx_state, tx_state_nxt;
   logic [CNT_W-1:0] tx_cnt, tx_cnt_nxt;
   logic [2:0]       tx_bit, tx_bit_nxt;
   logic [7:0]       tx_shift, tx_shift_nxt;
   logic             txd_nxt;

   uart_state_t      rx_state, rx_state_nxt;
   logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
   logic [2:0]       rx_bit, rx_bit_nxt;
   logic [7:0]       rx_shift, rx_shift_nxt;
   logic [1:0]       rx_sync;
   logic             rx_s, rx_prev, rx_push, rx_err_set;

   logic [OCC_W-1:0] rx_occ;
   logic [7:0]       stored_head, head_data;
   logic             pop, push_ok;

   assign uartWriteReady = (tx_state == IDLE);
   assign rx_s = rx_sync[1];

   always_comb begin
      tx_state_nxt = tx_state;
      tx_cnt_nxt   = tx_cnt;
      tx_bit_nxt   = tx_bit;
      tx_shift_nxt = tx_shift;
      txd_nxt      = 1'b1;
      case (tx_state)
         IDLE: if (uartWriteReq) begin
            tx_state_nxt = START;
            tx_cnt_nxt   = BIT_LAST;
            tx_shift_nxt = uartWriteData;
            txd_nxt      = 1'b0;
         end
         START: begin
            txd_nxt = 1'b0;
            if (tx_cnt == '0) begin
               tx_state_nxt = DATA;
               tx_cnt_nxt   = BIT_LAST;
               tx_bit_nxt   = 3'd7;
               txd_nxt      = tx_shift[0];
            end else tx_cnt_nxt = tx_cnt - CNT_ONE;
         end
         DATA: begin
            txd_nxt = tx_shift[0];
            if (tx_cnt == '0) begin
               tx_cnt_nxt = BIT_LAST;
               if (tx_bit == 3'd0) begin
                  tx_state_nxt = STOP;
                  txd_nxt      = 1'b1;
               end else begin
                  tx_bit_nxt   = tx_bit - 3'd1;
                  tx_shift_nxt = {1'b0, tx_shift[7:1]};
                  txd_nxt      = tx_shift[1];
               end
            end else tx_cnt_nxt = tx_cnt - CNT_ONE;
         end
         STOP: begin
            if (tx_cnt == '0) tx_state_nxt = IDLE;
            else tx_cnt_nxt = tx_cnt - CNT_ONE;
         end
         default: tx_state_nxt = IDLE;
      endcase
   end

   // After a framing error the FSM sits in IDLE; a new frame needs a fresh 1->0 edge.
   always_comb begin
      rx_state_nxt = rx_state;
      rx_cnt_nxt   = rx_cnt;
      rx_bit_nxt   = rx_bit;
      rx_shift_nxt = rx_shift;
      rx_push      = 1'b0;
      rx_err_set   = 1'b0;
      case (rx_state)
         IDLE: if (rx_prev && !rx_s) begin
            rx_state_nxt = START;
            rx_cnt_nxt   = HALF_LAST;
         end
         START: begin
            if (rx_cnt == '0) begin
               if (rx_s) rx_state_nxt = IDLE;
               else begin
                  rx_state_nxt = DATA;
                  rx_cnt_nxt   = BIT_LAST;
                  rx_bit_nxt   = 3'd7;
               end
            end else rx_cnt_nxt = rx_cnt - CNT_ONE;
         end
         DATA: begin
            if (rx_cnt == '0) begin
               rx_shift_nxt = {rx_s, rx_shift[7:1]};
               rx_cnt_nxt   = BIT_LAST;
               if (rx_bit == 3'd0) rx_state_nxt = STOP;
               else rx_bit_nxt = rx_bit - 3'd1;
            end else rx_cnt_nxt = rx_cnt - CNT_ONE;
         end
         STOP: begin
            if (rx_cnt == '0) begin
               rx_state_nxt = IDLE;
               rx_push      = rx_s;
               rx_err_set   = !rx_s;
            end else rx_cnt_nxt = rx_cnt - CNT_ONE;
         end
         default: rx_state_nxt = IDLE;
      endcase
   end

   // An empty store with a push in flight forwards the new byte straight to the reader.
   assign pop       = uartReadReq && !uartReadAck && ((rx_occ != '0) || rx_push);
   assign push_ok   = rx_push && ((rx_occ != OCC_FULL) || pop);
   assign head_data = (rx_occ != '0) ? stored_head : rx_shift;

`ifdef UART_PORT_RX_FIFO_EN
   logic [7:0]       rx_mem [RX_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;

   assign stored_head = rx_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) rx_mem[wr_ptr] <= rx_shift;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end
`else
   logic [7:0] rx_hold;

   assign stored_head = rx_hold;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rx_hold <= '0;
      else if (push_ok) rx_hold <= rx_shift;
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state     <= IDLE;
         tx_cnt       <= '0;
         tx_bit       <= '0;
         tx_shift     <= '0;
         txd          <= 1'b1;
         rx_state     <= IDLE;
         rx_cnt       <= '0;
         rx_bit       <= '0;
         rx_shift     <= '0;
         rx_sync      <= 2'b11;
         rx_prev      <= 1'b1;
         rx_occ       <= '0;
         uartReadAck  <= 1'b0;
         uartReadData <= '0;
         rxErr        <= 1'b0;
         rxOverrun    <= 1'b0;
      end else begin
         tx_state    <= tx_state_nxt;
         tx_cnt      <= tx_cnt_nxt;
         tx_bit      <= tx_bit_nxt;
         tx_shift    <= tx_shift_nxt;
         txd         <= txd_nxt;
         rx_state    <= rx_state_nxt;
         rx_cnt      <= rx_cnt_nxt;
         rx_bit      <= rx_bit_nxt;
         rx_shift    <= rx_shift_nxt;
         rx_sync     <= {rx_sync[0], rxd};
         rx_prev     <= rx_s;
         uartReadAck <= pop;
         if (pop) uartReadData <= head_data;
         rxErr       <= rx_err_set;
         rxOverrun   <= rx_push && !push_ok;
         if (push_ok && !pop)      rx_occ <= rx_occ + OCC_ONE;
         else if (!push_ok && pop) rx_occ <= rx_occ - OCC_ONE;
      end
   end
endmodule
